data_mem_sync: RTL and testbench

Parametrised, clocked successor to the combinational data memory. It sits on the datapath memory stage and serves one load or store at a time through a busy/done handshake. Depth and wait states are configurable. Accesses are byte, halfword or word, with sign/zero extension on loads. Misaligned, out-of-range and conflicting requests end with an error response instead of corrupting memory.

---
 rtl/data_mem_sync_if.sv | 24 ++
 rtl/data_mem_sync.sv | 153 +++++++++++++++
 tb/tb_data_mem_sync.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_sync_if.sv
// Request/response bundle between the memory-stage datapath and data_mem_sync.
// Signal names match the original flat port list so existing drivers map one-to-one.
interface data_mem_sync_if;
  logic [31:0] Address;
  logic [31:0] write_data;
  logic        memWrite;
  logic        MemRead;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output Address, write_data, memWrite, MemRead, size, load_unsigned,
    input  read_data, busy, done, err
  );

  modport slave (
    input  Address, write_data, memWrite, MemRead, size, load_unsigned,
    output read_data, busy, done, err
  );
endinterface

// File: rtl/data_mem_sync.sv
// Clocked data memory: one load/store at a time with configurable wait states,
// byte/half/word lanes, load sign/zero extension and error responses.
module data_mem_sync #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_sync_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_e;

  state_e        state_q;
  logic          rst_sync_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic          uns_q;
  logic          wr_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req;
  logic          bad;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wword;

  // Assertion is immediate; release reaches the FSM one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  always_comb begin
    req = bus.memWrite | bus.MemRead;
    bad = (bus.memWrite & bus.MemRead)
       || (bus.size == 2'b11)
       || (bus.size == 2'b01 && bus.Address[0])
       || (bus.size == 2'b10 && bus.Address[1:0] != 2'b00)
       || ((bus.Address >> (AW + 2)) != '0);
  end

  always_comb begin
    word     = mem_q[idx_q];
    shifted  = word >> {lane_q, 3'b000};
    load_val = word;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the target lanes.
  always_comb begin
    be    = 4'b1111;
    wword = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane_q;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lane_q;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == ACCESS && wr_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (bad) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              idx_q   <= bus.Address[AW+1:2];
              lane_q  <= bus.Address[1:0];
              size_q  <= bus.size;
              wdata_q <= bus.write_data;
              uns_q   <= bus.load_unsigned;
              wr_q    <= bus.memWrite;
              busy_q  <= 1'b1;
              if (WAIT_STATES != 0) begin
                cnt_q   <= 4'(WAIT_STATES - 1);
                state_q <= WAIT;
              end else begin
                state_q <= ACCESS;
              end
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= ACCESS;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        ACCESS: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (!wr_q) rdata_q <= load_val;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.read_data = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync: a 2-wait-state instance and a zero-wait instance,
// expected responses queued at issue and compared when done pulses.
module tb_data_mem_sync;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  data_mem_sync_if ia ();
  data_mem_sync_if ib ();

  data_mem_sync #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  data_mem_sync #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  logic        t_sel;
  logic [31:0] t_addr;
  logic [31:0] t_wd;
  logic [1:0]  t_sz;
  logic        t_uns;
  logic        t_wr;
  logic        t_rd;

  assign ia.Address       = t_addr;
  assign ia.write_data    = t_wd;
  assign ia.size          = t_sz;
  assign ia.load_unsigned = t_uns;
  assign ia.memWrite      = t_wr & ~t_sel;
  assign ia.MemRead       = t_rd & ~t_sel;
  assign ib.Address       = t_addr;
  assign ib.write_data    = t_wd;
  assign ib.size          = t_sz;
  assign ib.load_unsigned = t_uns;
  assign ib.memWrite      = t_wr & t_sel;
  assign ib.MemRead       = t_rd & t_sel;

  logic [31:0] o_rdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  assign o_rdata = t_sel ? ib.read_data : ia.read_data;
  assign o_busy  = t_sel ? ib.busy      : ia.busy;
  assign o_done  = t_sel ? ib.done      : ia.done;
  assign o_err   = t_sel ? ib.err       : ia.err;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [31:0] rd_model [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the done pulse.
  task automatic op(input logic sel, input logic wr, input logic rd, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                    input logic exp_err, input logic [31:0] load_exp, input string tag);
    int unsigned w;
    int unsigned lat;
    int unsigned bcnt;
    int unsigned guard;
    logic        got;
    exp_t        e;
    w = sel ? 0 : 2;
    e.err = exp_err;
    e.rd  = (rd && !wr && !exp_err) ? load_exp : rd_model[sel];
    rd_model[sel] = e.rd;
    sb.push_back(e);
    t_sel = sel; t_addr = addr; t_wd = wd; t_sz = sz; t_uns = uns;
    t_wr = wr;   t_rd = rd;
    @(posedge clk);
    lat = 0; bcnt = 0; guard = 0; got = 1'b0;
    while (!got && guard < 40) begin
      @(negedge clk);
      guard++;
      t_wr = 1'b0;
      t_rd = 1'b0;
      if (o_done) got = 1'b1;
      else begin
        if (o_busy) bcnt++;
        lat++;
      end
    end
    check({tag, ".done"}, 32'(got), 32'd1);
    check({tag, ".lat"}, lat, exp_err ? 32'd0 : w + 1);
    check({tag, ".busycyc"}, bcnt, exp_err ? 32'd0 : w + 1);
    check({tag, ".busy_at_done"}, 32'(o_busy), 32'd0);
    e = sb.pop_front();
    check({tag, ".err"}, 32'(o_err), 32'(e.err));
    check({tag, ".rdata"}, o_rdata, e.rd);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    t_sel = 1'b0; t_addr = '0; t_wd = '0; t_sz = '0; t_uns = 1'b0;
    t_wr = 1'b0; t_rd = 1'b0;
    rd_model[0] = '0;
    rd_model[1] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst.rdata", ia.read_data, 32'h0);
    check("rst.busy", 32'(ia.busy), 32'd0);
    check("rst.done", 32'(ia.done), 32'd0);
    check("rst.err", 32'(ia.err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word round trip and last-word boundary
    op(0, 1, 0, 2'b10, 0, 32'h40,  32'hDEADBEEF, 0, 32'h0,        "st_w40");
    op(0, 0, 1, 2'b10, 0, 32'h40,  32'h0,        0, 32'hDEADBEEF, "ld_w40");
    op(0, 1, 0, 2'b10, 0, 32'h3FC, 32'h0F1E2D3C, 0, 32'h0,        "st_w3fc");
    op(0, 0, 1, 2'b10, 0, 32'h3FC, 32'h0,        0, 32'h0F1E2D3C, "ld_w3fc");
    op(0, 1, 0, 2'b10, 0, 32'h0,   32'h13579BDF, 0, 32'h0,        "st_w0");

    // Byte lanes
    op(0, 1, 0, 2'b00, 0, 32'h80, 32'hFFFFFF11, 0, 32'h0, "st_b80");
    op(0, 1, 0, 2'b00, 0, 32'h81, 32'h00000022, 0, 32'h0, "st_b81");
    op(0, 1, 0, 2'b00, 0, 32'h82, 32'h00000083, 0, 32'h0, "st_b82");
    op(0, 1, 0, 2'b00, 0, 32'h83, 32'h00000044, 0, 32'h0, "st_b83");
    op(0, 0, 1, 2'b10, 0, 32'h80, 32'h0, 0, 32'h44832211, "ld_w80");
    op(0, 0, 1, 2'b00, 0, 32'h82, 32'h0, 0, 32'hFFFFFF83, "ld_sb82");
    op(0, 0, 1, 2'b00, 1, 32'h82, 32'h0, 0, 32'h00000083, "ld_ub82");
    op(0, 0, 1, 2'b01, 0, 32'h82, 32'h0, 0, 32'h00004483, "ld_sh82");
    op(0, 0, 1, 2'b00, 1, 32'h81, 32'h0, 0, 32'h00000022, "ld_ub81");
    op(0, 0, 1, 2'b01, 0, 32'h80, 32'h0, 0, 32'h00002211, "ld_sh80");

    // Half store into upper lanes
    op(0, 1, 0, 2'b10, 0, 32'h10, 32'hA5A50F0F, 0, 32'h0, "st_w10");
    op(0, 1, 0, 2'b01, 0, 32'h12, 32'h12348001, 0, 32'h0, "st_h12");
    op(0, 0, 1, 2'b01, 0, 32'h12, 32'h0, 0, 32'hFFFF8001, "ld_sh12");
    op(0, 0, 1, 2'b01, 1, 32'h12, 32'h0, 0, 32'h00008001, "ld_uh12");
    op(0, 0, 1, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80010F0F, "ld_w10");

    // Error responses: read_data and memory must stay untouched
    op(0, 0, 1, 2'b10, 0, 32'h41,  32'h0, 1, 32'h0, "err_w41");
    op(0, 0, 1, 2'b01, 0, 32'h43,  32'h0, 1, 32'h0, "err_h43");
    op(0, 0, 1, 2'b11, 0, 32'h40,  32'h0, 1, 32'h0, "err_sz11");
    op(0, 1, 1, 2'b10, 0, 32'h40,  32'h0, 1, 32'h0, "err_both");
    op(0, 0, 1, 2'b10, 0, 32'h400, 32'h0, 1, 32'h0, "err_oor_ld");
    op(0, 1, 0, 2'b10, 0, 32'h400, 32'h0, 1, 32'h0, "err_oor_st");
    op(0, 1, 0, 2'b10, 0, 32'h41,  32'h0, 1, 32'h0, "err_mis_st");
    op(0, 0, 1, 2'b10, 0, 32'h40,  32'h0, 0, 32'hDEADBEEF, "ld_w40_kept");
    op(0, 0, 1, 2'b10, 0, 32'h0,   32'h0, 0, 32'h13579BDF, "ld_w0_kept");

    // Reset aborts an in-flight store
    op(0, 1, 0, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0, "st_w20");
    t_sel = 1'b0; t_addr = 32'h20; t_wd = 32'h12345678; t_sz = 2'b10; t_uns = 1'b0;
    t_wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_wr = 1'b0;
    check("abort.busy", 32'(ia.busy), 32'd1);
    @(negedge clk);
    check("abort.nodone", 32'(ia.done), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort.rdata", ia.read_data, 32'h0);
    check("abort.busy0", 32'(ia.busy), 32'd0);
    check("abort.done0", 32'(ia.done), 32'd0);
    check("abort.err0", 32'(ia.err), 32'd0);
    rd_model[0] = '0;
    rd_model[1] = '0;
    @(negedge clk);
    @(negedge clk);
    check("abort.hold_nodone", 32'(ia.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 0, 1, 2'b10, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D, "ld_w20_after_abort");

    // Zero-wait instance: latched address while busy, continuous MemRead
    op(1, 1, 0, 2'b10, 0, 32'h100, 32'h11223344, 0, 32'h0, "b_st100");
    op(1, 1, 0, 2'b10, 0, 32'h104, 32'h55667788, 0, 32'h0, "b_st104");
    t_sel = 1'b1; t_addr = 32'h100; t_sz = 2'b10; t_uns = 1'b0; t_rd = 1'b1;
    sb.push_back('{rd: 32'h11223344, err: 1'b0});
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b_stream.done", 32'(o_done), 32'(i % 2));
      if (o_done) begin
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("b_stream.rdata", o_rdata, e.rd);
        end else begin
          check("b_stream.sb_underflow", 32'd1, 32'd0);
        end
      end
      if (i == 7) t_rd = 1'b0;
      else if (o_busy) t_addr = 32'h104;
      else begin
        t_addr = 32'h100;
        sb.push_back('{rd: 32'h11223344, err: 1'b0});
      end
    end
    check("sb.empty", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    check("b_idle.busy", 32'(ib.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
